// File: rtl/fa16_rev_driver.sv
// Digital sequencer for the 16-bit reversible dual-rail adder: forward compute,
// null, reverse (uncompute) with operand check, null, then result handshake.
module fa16_rev_driver #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_cout,
  output logic        rail_err,
  output logic        rev_err,
  output logic [15:0] a_o,
  output logic [15:0] a_not_o,
  output logic [15:0] b_o,
  output logic [15:0] b_not_o,
  output logic        c0_f_o,
  output logic        c0_f_not_o,
  output logic        z_o,
  output logic        z_not_o,
  output logic        fwd_oe,
  output logic        b_oe,
  output logic [15:0] s_o,
  output logic [15:0] s_not_o,
  output logic        c15_o,
  output logic        c15_not_o,
  output logic        rev_oe,
  input  logic [15:0] s_i,
  input  logic [15:0] s_not_i,
  input  logic        c15_i,
  input  logic        c15_not_i,
  input  logic [15:0] a_b_i,
  input  logic [15:0] a_not_b_i,
  input  logic        c0_b_i,
  input  logic        c0_not_b_i
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_NULL1, S_REV, S_NULL2, S_RESP
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           w_last, w_accept;
  logic [W-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic           r_cin, w_cin_nxt;
  logic [W-1:0]   r_sum;
  logic           r_cout, r_rail_err, r_rev_err;

  logic           r_in_ready, r_out_valid;
  logic [W-1:0]   r_a_o, r_a_not_o, r_b_o, r_b_not_o, r_s_o, r_s_not_o;
  logic           r_c0_f_o, r_c0_f_not_o, r_z_o, r_z_not_o;
  logic           r_c15_o, r_c15_not_o, r_fwd_oe, r_b_oe, r_rev_oe;

  assign w_last    = (r_cnt == CW'(SETTLE - 1));
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_a_nxt   = w_accept ? in_a   : r_a;
  assign w_b_nxt   = w_accept ? in_b   : r_b;
  assign w_cin_nxt = w_accept ? in_cin : r_cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_FWD;
      S_FWD:   if (w_last)    w_state_nxt = S_NULL1;
      S_NULL1: if (w_last)    w_state_nxt = S_REV;
      S_REV:   if (w_last)    w_state_nxt = S_NULL2;
      S_NULL2: if (w_last)    w_state_nxt = S_RESP;
      S_RESP:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Phase counter restarts whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (w_state_nxt != r_state) r_cnt <= '0;
    else                             r_cnt <= r_cnt + CW'(1);
  end

  // Operand latch, result capture and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_cin <= 1'b0;
      r_sum <= '0; r_cout <= 1'b0;
      r_rail_err <= 1'b0; r_rev_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= in_a; r_b <= in_b; r_cin <= in_cin;
        r_rail_err <= 1'b0; r_rev_err <= 1'b0;
      end
      if (r_state == S_FWD && w_last) begin
        r_sum  <= s_i;
        r_cout <= c15_i;
        if (!(&(s_i ^ s_not_i)) || (c15_i == c15_not_i)) r_rail_err <= 1'b1;
      end
      if (r_state == S_REV && w_last) begin
        if (!(&(a_b_i ^ a_not_b_i)) || (c0_b_i == c0_not_b_i)) r_rail_err <= 1'b1;
        if ((a_b_i != r_a) || (c0_b_i != r_cin)) r_rev_err <= 1'b1;
      end
    end
  end

  // Rail and handshake outputs are registered from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b1; r_out_valid <= 1'b0;
      r_a_o <= '0; r_a_not_o <= '0; r_b_o <= '0; r_b_not_o <= '0;
      r_s_o <= '0; r_s_not_o <= '0;
      r_c0_f_o <= 1'b0; r_c0_f_not_o <= 1'b0; r_z_o <= 1'b0; r_z_not_o <= 1'b0;
      r_c15_o <= 1'b0; r_c15_not_o <= 1'b0;
      r_fwd_oe <= 1'b0; r_b_oe <= 1'b0; r_rev_oe <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_RESP);
      r_a_o <= '0; r_a_not_o <= '0; r_b_o <= '0; r_b_not_o <= '0;
      r_s_o <= '0; r_s_not_o <= '0;
      r_c0_f_o <= 1'b0; r_c0_f_not_o <= 1'b0; r_z_o <= 1'b0; r_z_not_o <= 1'b0;
      r_c15_o <= 1'b0; r_c15_not_o <= 1'b0;
      r_fwd_oe <= 1'b0; r_b_oe <= 1'b0; r_rev_oe <= 1'b0;
      case (w_state_nxt)
        S_FWD: begin
          r_fwd_oe <= 1'b1; r_b_oe <= 1'b1;
          r_a_o <= w_a_nxt; r_a_not_o <= ~w_a_nxt;
          r_b_o <= w_b_nxt; r_b_not_o <= ~w_b_nxt;
          r_c0_f_o <= w_cin_nxt; r_c0_f_not_o <= ~w_cin_nxt;
          r_z_not_o <= 1'b1;
        end
        S_NULL1: begin
          r_b_oe <= 1'b1;
          r_b_o <= w_b_nxt; r_b_not_o <= ~w_b_nxt;
        end
        S_REV: begin
          r_b_oe <= 1'b1; r_rev_oe <= 1'b1;
          r_b_o <= w_b_nxt; r_b_not_o <= ~w_b_nxt;
          r_s_o <= r_sum; r_s_not_o <= ~r_sum;
          r_c15_o <= r_cout; r_c15_not_o <= ~r_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sum    = r_sum;
  assign out_cout   = r_cout;
  assign rail_err   = r_rail_err;
  assign rev_err    = r_rev_err;
  assign a_o        = r_a_o;
  assign a_not_o    = r_a_not_o;
  assign b_o        = r_b_o;
  assign b_not_o    = r_b_not_o;
  assign c0_f_o     = r_c0_f_o;
  assign c0_f_not_o = r_c0_f_not_o;
  assign z_o        = r_z_o;
  assign z_not_o    = r_z_not_o;
  assign fwd_oe     = r_fwd_oe;
  assign b_oe       = r_b_oe;
  assign s_o        = r_s_o;
  assign s_not_o    = r_s_not_o;
  assign c15_o      = r_c15_o;
  assign c15_not_o  = r_c15_not_o;
  assign rev_oe     = r_rev_oe;

endmodule

// File: tb/tb_fa16_rev_driver.sv
// Bench for fa16_rev_driver: behavioural dual-rail adder model, directed and
// random transactions, fault injection in the model, and mid-operation reset.
module tb_fa16_rev_driver;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_cin, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_sum;
  logic        out_cout, rail_err, rev_err;
  logic [15:0] a_o, a_not_o, b_o, b_not_o, s_o, s_not_o;
  logic        c0_f_o, c0_f_not_o, z_o, z_not_o, fwd_oe, b_oe;
  logic        c15_o, c15_not_o, rev_oe;
  logic [15:0] s_i, s_not_i, a_b_i, a_not_b_i;
  logic        c15_i, c15_not_i, c0_b_i, c0_not_b_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Adder model knobs set per transaction.
  logic        m_cin;
  logic        m_snot_fault;
  logic [15:0] m_rev_flip;
  logic [16:0] m_fwd, m_rev;

  always #5 clk = ~clk;

  fa16_rev_driver #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .rail_err(rail_err), .rev_err(rev_err),
    .a_o(a_o), .a_not_o(a_not_o), .b_o(b_o), .b_not_o(b_not_o),
    .c0_f_o(c0_f_o), .c0_f_not_o(c0_f_not_o), .z_o(z_o), .z_not_o(z_not_o),
    .fwd_oe(fwd_oe), .b_oe(b_oe), .s_o(s_o), .s_not_o(s_not_o),
    .c15_o(c15_o), .c15_not_o(c15_not_o), .rev_oe(rev_oe),
    .s_i(s_i), .s_not_i(s_not_i), .c15_i(c15_i), .c15_not_i(c15_not_i),
    .a_b_i(a_b_i), .a_not_b_i(a_not_b_i), .c0_b_i(c0_b_i), .c0_not_b_i(c0_not_b_i)
  );

  // Forward: sum of the driven rails. Reverse: subtract b and the known carry-in
  // from the driven {c15,s} to recover a. Undriven => all rails null.
  always_comb begin
    m_fwd     = {1'b0, a_o} + {1'b0, b_o} + {16'b0, c0_f_o};
    m_rev     = {c15_o, s_o} - {1'b0, b_o} - {16'b0, m_cin};
    s_i       = fwd_oe ? m_fwd[15:0] : 16'h0;
    s_not_i   = fwd_oe ? (~m_fwd[15:0] ^ (m_snot_fault ? 16'h0020 : 16'h0)) : 16'h0;
    c15_i     = fwd_oe ? m_fwd[16] : 1'b0;
    c15_not_i = fwd_oe ? ~m_fwd[16] : 1'b0;
    a_b_i     = rev_oe ? (m_rev[15:0] ^ m_rev_flip) : 16'h0;
    a_not_b_i = rev_oe ? ~(m_rev[15:0] ^ m_rev_flip) : 16'h0;
    c0_b_i    = rev_oe ? m_cin : 1'b0;
    c0_not_b_i = rev_oe ? ~m_cin : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; out_ready stays low for `hold` extra RESP cycles.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic snot_fault, input logic [15:0] rev_flip, input int hold);
    logic [16:0] total;
    logic [15:0] es;
    logic        ec;
    int          ph;
    total = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    es = total[15:0];
    ec = total[16];
    m_cin = cin; m_snot_fault = snot_fault; m_rev_flip = rev_flip;
    check("ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    // Busy-time requests with junk operands must be ignored.
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    for (int k = 1; k <= 4 * S; k++) begin
      ph = (k - 1) / S;
      check("busy_hs", {62'd0, out_valid, in_ready}, 64'd0);
      check("oe", {61'd0, fwd_oe, b_oe, rev_oe},
            {61'd0, ph == 0, ph <= 2, ph == 2});
      check("a_rails", {32'd0, a_o, a_not_o}, (ph == 0) ? {32'd0, a, ~a} : 64'd0);
      check("b_rails", {32'd0, b_o, b_not_o}, (ph <= 2) ? {32'd0, b, ~b} : 64'd0);
      check("cz_rails", {60'd0, c0_f_o, c0_f_not_o, z_o, z_not_o},
            (ph == 0) ? {60'd0, cin, ~cin, 1'b0, 1'b1} : 64'd0);
      check("s_rails", {30'd0, c15_o, c15_not_o, s_o, s_not_o},
            (ph == 2) ? {30'd0, ec, ~ec, es, ~es} : 64'd0);
      if (k == 4 * S) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("resp_valid", {62'd0, out_valid, in_ready}, 64'd2);
    check("result", {46'd0, out_sum, out_cout, rail_err, rev_err},
          {46'd0, es, ec, snot_fault, rev_flip != 16'h0});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("resp_hold", {44'd0, out_valid, in_ready, out_sum, out_cout, rail_err, rev_err},
            {44'd0, 1'b1, 1'b0, es, ec, snot_fault, rev_flip != 16'h0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("resp_done", {62'd0, out_valid, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    m_cin = 1'b0; m_snot_fault = 1'b0; m_rev_flip = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hs", {62'd0, in_ready, out_valid}, 64'd2);
    check("reset_res", {45'd0, out_sum, out_cout, rail_err, rev_err, fwd_oe}, 64'd0);
    check("reset_rails", {a_o | a_not_o | b_o | b_not_o | s_o | s_not_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0000, 0);
    run_txn(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 0);
    run_txn(16'hA5A5, 16'h0F0F, 1'b0, 1'b1, 16'h0000, 0);
    run_txn(16'h7777, 16'h1111, 1'b1, 1'b0, 16'h0100, 0);
    run_txn(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 10);
    for (int t = 0; t < 10; t++)
      run_txn(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0,
              int'($urandom_range(0, 3)));
    // Errors from a faulty transaction must clear on the next accept.
    run_txn(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1);

    // Reset in the middle of the reverse phase.
    m_cin = 1'b1; m_snot_fault = 1'b0; m_rev_flip = '0;
    in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h3030; in_cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2 * S + 1) @(posedge clk);
    #1;
    check("mid_rev_active", {62'd0, rev_oe, b_oe}, 64'd3);
    rst = 1'b1;
    #1;
    check("rst_oe", {61'd0, fwd_oe, b_oe, rev_oe}, 64'd0);
    check("rst_rails", {32'd0, b_o | b_not_o, s_o | s_not_o}, 64'd0);
    check("rst_c15", {62'd0, c15_o, c15_not_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_hs", {62'd0, in_ready, out_valid}, 64'd2);
    check("post_rst_sum", {47'd0, out_sum, out_cout}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4 * S + 4; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("no_stale_result", 64'(seen), 64'd0);
    run_txn(16'h0101, 16'h0202, 1'b1, 1'b0, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa16_rev_driver.md
# fa16_rev_driver

Synchronous sequencer on the digital side of the 16-bit reversible dual-rail adder. It accepts an operand pair and carry-in over a valid/ready handshake and drives the adder's dual-rail inputs through a forward compute phase. It then drives the captured sum back through a reverse (uncompute) phase, checks that the recovered operands match, and returns sum, carry and error flags. Between phases it returns every rail pair to the null state (both rails low).

## Interface
- SETTLE, default 4, cycles each drive or null phase lasts; legal range 1..255.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- in_a, in_b  in  16  operands.
- in_cin  in  1  carry-in.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- out_sum  out  16  captured sum.
- out_cout  out  1  captured c15.
- rail_err  out  1  any sampled pair not exactly one-hot.
- rev_err  out  1  recovered a / c0 mismatched the operands.
- a_o, a_not_o, b_o, b_not_o  out  16  dual-rail operand drive.
- c0_f_o, c0_f_not_o, z_o, z_not_o  out  1  carry-in and ancilla drive.
- fwd_oe  out  1  enables the a, c0_f and z drivers.
- b_oe  out  1  enables the b drivers.
- s_o, s_not_o  out  16  reverse-phase sum drive.
- c15_o, c15_not_o  out  1  reverse-phase carry drive.
- rev_oe  out  1  enables the s and c15 drivers.
- s_i, s_not_i  in  16  adder sum rails.
- c15_i, c15_not_i  in  1  adder carry rails.
- a_b_i, a_not_b_i  in  16  recovered operand rails.
- c0_b_i, c0_not_b_i  in  1  recovered carry rails.

## Operation
- The design uses one clock; reset is asynchronous and active-high.
- States: IDLE, FWD, NULL1, REV, NULL2, RESP. Each of FWD, NULL1, REV and NULL2 lasts exactly SETTLE cycles, timed by a phase counter that reloads on every state change.
- IDLE:
  - All rail outputs are 0 and all oe signals are 0; in_ready=1.
  - When in_valid && in_ready, the block latches in_a, in_b and in_cin, clears both error flags, and moves to FWD.
- FWD:
  - fwd_oe=1 and b_oe=1.
  - a_o=A, a_not_o=~A, b_o=B, b_not_o=~B, c0_f_o=cin, c0_f_not_o=~cin, z_o=0, z_not_o=1.
  - On the last cycle's edge it captures s_i into the sum register and c15_i into the carry register.
  - rail_err is set if any bit of s_i^s_not_i is 0, or if c15_i==c15_not_i.
- NULL1:
  - a, c0_f and z rails go to 0 and fwd_oe=0.
  - b stays driven with b_oe=1, because b is a preserved input that the reverse phase needs.
- REV:
  - rev_oe=1; s_o=sum, s_not_o=~sum, c15_o=cout, c15_not_o=~cout. b is still driven.
  - On the last cycle's edge the recovered rails are checked:
    - rail_err is set on any non-one-hot a_b/a_not_b or c0_b/c0_not_b pair.
    - rev_err is set if a_b_i!=A or c0_b_i!=cin.
- NULL2: all rail outputs are 0 and all oe signals are 0.
- RESP:
  - out_valid=1; out_sum, out_cout and the error flags are stable.
  - On out_ready the block returns to IDLE.
- Errors never abort the sequence. The flags are sticky until the next accept.
- Within a state, every driven rail pair is exactly complementary. A pair is never driven 1/1.

## Timing
- Reset state:
  - State IDLE; all rail outputs and oe signals 0; in_ready=1; out_valid=0.
  - out_sum=0, out_cout=0, rail_err=0, rev_err=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Accept edge at t0:
  - FWD occupies cycles t0+1..t0+SETTLE.
  - NULL1 ends at t0+2·SETTLE.
  - REV ends at t0+3·SETTLE.
  - NULL2 ends at t0+4·SETTLE.
  - out_valid rises at t0+4·SETTLE+1.
- If out_ready is already high on the first RESP cycle, out_valid is a one-cycle pulse. The next accept can occur at the earliest one cycle later, because in_ready rises in IDLE.
- SETTLE=1 is legal: each phase is one cycle and latency is 5 cycles.
- Reset asserted mid-operation immediately forces all oe signals and rails to 0 and the state to IDLE. The pending result is discarded.
- in_valid outside IDLE is ignored, and the inputs are not sampled.

## Test plan
- Reset mid-REV (SETTLE=4): assert rst → rev_oe, b_oe and all rails 0 immediately; after release in_ready=1 and out_valid=0.
- Ideal adder model, SETTLE=4: A=0x1234, B=0x4321, cin=0 → out_valid at accept+17, out_sum=0x5555, out_cout=0, no errors.
- A=0xFFFF, B=0x0001, cin=1 → out_sum=0x0001, out_cout=1, no errors.
- Model corrupts s_not_i bit 5 to equal s_i[5] → rail_err=1, rev_err=0, sequence still completes on time.
- Model returns a_b_i = A^0x0100 → rev_err=1, rail_err=0.
- out_ready held low for 10 cycles in RESP → outputs stable, in_ready=0, then completion on out_ready.
- Back-to-back transactions with out_ready tied high → in_ready asserts exactly one cycle after the out_valid pulse.
